interp_line_sel_seq: RTL
========================

# interp_line_sel_seq

Parametrised, registered line-source selector for the interpolation datapath, succeeding the fixed 99-bit buffer/external-line mux. Picks one of NUM_SRC line sources (source 0 = buffer column, source 1 = external line, others spare), either directly from SELECT (manual) or from an internal per-block line sequencer (auto). Adds a valid/ready output stage, per-source acknowledge and block-done signalling. Sits between the line buffer / external line fetch and the interpolation filter array.

## Interface
- SAMPLE_W, 9, bits per sample
- NUM_SAMPLES, 11, samples per line; line width LW = SAMPLE_W*NUM_SAMPLES (99 by default)
- NUM_SRC, 2, number of line sources, 2..8; SEL_W = max(1, clog2(NUM_SRC))
- LINES_PER_BLOCK, 8, lines per block in auto mode, 1..255
- EXT_LINES, 1, leading lines of each auto block taken from source 1, 0..LINES_PER_BLOCK
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  starts an auto block when in IDLE; AUTO_MODE is sampled at the same time
- AUTO_MODE  in  1  1 = sequencer selects the source, 0 = SELECT selects it
- SELECT  in  SEL_W  manual source index
- DATA_IN  in  NUM_SRC*LW  packed lines; source k occupies bits [k*LW +: LW]
- VALID_IN  in  NUM_SRC  per-source line valid
- SRC_ACK  out  NUM_SRC  one-hot, combinational; the selected source's line is consumed this cycle
- READY_IN  in  1  downstream ready
- DATA_OUT  out  LW  registered line
- VALID_OUT  out  1  DATA_OUT valid
- SEL_OUT  out  SEL_W  source index of the line in DATA_OUT
- LINE_IDX  out  8  index of the next line to fetch in the current auto block
- BUSY  out  1  auto block in progress
- DONE  out  1  one-cycle pulse coinciding with VALID_OUT rising for the last line of the block
- EXT_CNT  out  16  count of lines taken from source 1 (see Configuration)

## Operation
- FSM states: IDLE, RUN.
  - IDLE + START + AUTO_MODE=1 -> RUN, LINE_IDX=0.
  - RUN -> IDLE on the accept of line LINES_PER_BLOCK-1.
  - START is ignored in RUN.
  - AUTO_MODE and SELECT are ignored in RUN.
- Effective source `sel`:
  - RUN: 1 if LINE_IDX < EXT_LINES, else 0.
  - IDLE: SELECT when AUTO_MODE=0; otherwise no source.
- `sel_ok` = a source is selected, sel < NUM_SRC, and VALID_IN[sel].
- `load` = sel_ok && (!VALID_OUT || READY_IN); SRC_ACK[sel] = load, all other SRC_ACK bits 0.
- Register updates each clock:
  - On load: DATA_OUT <= DATA_IN[sel], SEL_OUT <= sel, VALID_OUT <= 1.
  - In RUN, also LINE_IDX <= LINE_IDX+1.
  - Else if READY_IN: VALID_OUT <= 0, DATA_OUT and SEL_OUT hold.
  - Else: everything holds.
- SELECT >= NUM_SRC: no acknowledge, no load; the output drains normally.
- DONE <= 1 on the load of the last block line, 0 otherwise.
- BUSY = (state == RUN).
- Reset values: DATA_OUT 0, VALID_OUT 0, SEL_OUT 0, LINE_IDX 0, BUSY 0, DONE 0, EXT_CNT 0; FSM in IDLE.

## Timing
- Latency 1 cycle from the SRC_ACK cycle to VALID_OUT/DATA_OUT.
- Throughput 1 line/cycle while READY_IN=1.
- Backpressure: with VALID_OUT=1 and READY_IN=0, DATA_OUT is stable and no source is acknowledged.
- A simultaneous drain and load in one cycle is allowed; VALID_OUT stays 1.
- EXT_LINES=0: every auto line comes from source 0. EXT_LINES=LINES_PER_BLOCK: every auto line comes from source 1.
- LINES_PER_BLOCK=1: RUN lasts until the single accept; DONE comes on the next cycle.
- START in the same cycle as the last-line accept is ignored (FSM is still in RUN). START on the cycle after is accepted.
- RST_N asserted mid-block: immediate return to reset values. The partial block is discarded and DONE is not asserted.

## Configuration
- INTERP_LINE_SEL_STATS_EN defined:
  - EXT_CNT increments on every load with sel == 1, in both modes.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: EXT_CNT is constant 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Manual mode, defaults: SELECT=0, VALID_IN=2'b11, DATA_IN[0]=99'h1A5 -> SRC_ACK=2'b01, next cycle DATA_OUT=99'h1A5, VALID_OUT=1, SEL_OUT=0. Repeat with SELECT=1.
- Auto block, LINES_PER_BLOCK=8, EXT_LINES=1, all valid, READY_IN=1, START pulse:
  - SRC_ACK=2'b10 for line 0, then 2'b01 for lines 1..7.
  - BUSY high for 8 cycles.
  - DONE pulses once with the 8th VALID_OUT.
  - LINE_IDX returns to 0.
- Backpressure: READY_IN=0 for 3 cycles mid-block -> DATA_OUT frozen, SRC_ACK=0, LINE_IDX frozen. Resume gives no lost or duplicated lines; the block still yields exactly 8 lines.
- Edge cases:
  - NUM_SRC=3, SELECT=3 -> no acknowledge, VALID_OUT drops after the pending line drains.
  - START while BUSY -> ignored.
  - RST_N low after line 4 -> all outputs 0, IDLE, no DONE.
- Stats macro:
  - With INTERP_LINE_SEL_STATS_EN, two auto blocks with EXT_LINES=3 -> EXT_CNT=6.
  - Without the macro -> EXT_CNT=0 throughout.

Source files
------------

// File: rtl/interp_line_sel_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | interp_line_sel_seq_if : line-source selector bus (sources in, line out)|
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
interface interp_line_sel_seq_if #(
  parameter int SAMPLE_W    = 9,
  parameter int NUM_SAMPLES = 11,
  parameter int NUM_SRC     = 2
);
  localparam int LW    = SAMPLE_W * NUM_SAMPLES;
  localparam int SEL_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  logic                  i_start;
  logic                  i_auto_mode;
  logic [SEL_W-1:0]      i_select;
  logic [NUM_SRC*LW-1:0] i_data_in;
  logic [NUM_SRC-1:0]    i_valid_in;
  logic [NUM_SRC-1:0]    o_src_ack;
  logic                  i_ready_in;
  logic [LW-1:0]         o_data_out;
  logic                  o_valid_out;
  logic [SEL_W-1:0]      o_sel_out;
  logic [7:0]            o_line_idx;
  logic                  o_busy;
  logic                  o_done;
  logic [15:0]           o_ext_cnt;

  modport slave (
    input  i_start, i_auto_mode, i_select, i_data_in, i_valid_in, i_ready_in,
    output o_src_ack, o_data_out, o_valid_out, o_sel_out, o_line_idx,
           o_busy, o_done, o_ext_cnt
  );

  modport master (
    output i_start, i_auto_mode, i_select, i_data_in, i_valid_in, i_ready_in,
    input  o_src_ack, o_data_out, o_valid_out, o_sel_out, o_line_idx,
           o_busy, o_done, o_ext_cnt
  );
endinterface
`default_nettype wire

// File: rtl/interp_line_sel_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | interp_line_sel_seq : registered line-source selector, manual/auto seq  |
// | Optional source-1 line counter: define INTERP_LINE_SEL_STATS_EN         |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module interp_line_sel_seq #(
  parameter int SAMPLE_W        = 9,
  parameter int NUM_SAMPLES     = 11,
  parameter int NUM_SRC         = 2,
  parameter int LINES_PER_BLOCK = 8,
  parameter int EXT_LINES       = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  interp_line_sel_seq_if.slave bus
);
  localparam int LW    = SAMPLE_W * NUM_SAMPLES;
  localparam int SEL_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  localparam logic [7:0]       c_LAST_IDX  = 8'(LINES_PER_BLOCK - 1);
  localparam logic [7:0]       c_EXT_LINES = 8'(EXT_LINES);
  localparam logic [SEL_W-1:0] c_SEL_EXT   = SEL_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [LW-1:0]    r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic [7:0]       r_line_idx;
  logic             r_done;

  logic               w_has_sel;
  logic [SEL_W-1:0]   w_sel;
  logic               w_src_valid;
  logic [LW-1:0]      w_src_data;
  logic               w_load;
  logic               w_last;
  logic [NUM_SRC-1:0] w_ack;

  // Auto mode: leading EXT_LINES lines of a block from source 1, rest from 0.
  always_comb begin
    w_has_sel = 1'b0;
    w_sel     = '0;
    if (r_state == ST_RUN) begin
      w_has_sel = 1'b1;
      w_sel     = (r_line_idx < c_EXT_LINES) ? c_SEL_EXT : '0;
    end else if (!bus.i_auto_mode) begin
      w_has_sel = 1'b1;
      w_sel     = bus.i_select;
    end
  end

  // An out-of-range index matches no source, so it never loads.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_src_valid = bus.i_valid_in[k];
        w_src_data  = bus.i_data_in[k*LW +: LW];
      end
    end
  end

  assign w_load = w_has_sel && w_src_valid && (!r_valid || bus.i_ready_in);
  assign w_last = (r_line_idx == c_LAST_IDX);

  always_comb begin
    w_ack = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_ack[k] = w_load && (w_sel == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_line_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_data  <= w_src_data;
        r_sel   <= w_sel;
        r_valid <= 1'b1;
      end else if (bus.i_ready_in) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start && bus.i_auto_mode) begin
            r_state    <= ST_RUN;
            r_line_idx <= '0;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_line_idx <= '0;
              r_done     <= 1'b1;
            end else begin
              r_line_idx <= r_line_idx + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef INTERP_LINE_SEL_STATS_EN
  logic [15:0] r_ext_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_cnt <= '0;
    end else if (w_load && (w_sel == c_SEL_EXT) && (r_ext_cnt != 16'hFFFF)) begin
      r_ext_cnt <= r_ext_cnt + 16'd1;
    end
  end

  assign bus.o_ext_cnt = r_ext_cnt;
`else
  assign bus.o_ext_cnt = '0;
`endif

  assign bus.o_src_ack   = w_ack;
  assign bus.o_data_out  = r_data;
  assign bus.o_valid_out = r_valid;
  assign bus.o_sel_out   = r_sel;
  assign bus.o_line_idx  = r_line_idx;
  assign bus.o_busy      = (r_state == ST_RUN);
  assign bus.o_done      = r_done;
endmodule
`default_nettype wire
